// File: rtl/hazard_pkg.sv
// Shared types and helpers for the ID-stage operand hazard scoreboard.
// Entry fields are sized by the default register and stage widths below.
package hazard_pkg;

   localparam int REG_BITS_DEF = 5;
   localparam int DEPTH_DEF    = 3;
   localparam int SEL_W_DEF    = $clog2(DEPTH_DEF + 1);

   localparam logic [SEL_W_DEF-1:0] SEL_REGFILE = {SEL_W_DEF{1'b0}};

   typedef struct packed {
      logic                    valid;
      logic [REG_BITS_DEF-1:0] rd;
      logic [SEL_W_DEF-1:0]    avail;
   } entry_t;

   localparam entry_t ENTRY_NONE = '{valid: 1'b0,
                                     rd:    {REG_BITS_DEF{1'b0}},
                                     avail: {SEL_W_DEF{1'b0}}};

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      STALL = 1'b1
   } state_t;

   // A writer can never be forwardable before stage 1 or after the last tracked stage.
   function automatic logic [SEL_W_DEF-1:0] clamp_avail(input logic [SEL_W_DEF-1:0] avail,
                                                        input logic [SEL_W_DEF-1:0] depth);
      logic [SEL_W_DEF-1:0] result;
      if (avail == {SEL_W_DEF{1'b0}}) begin
         result = {{(SEL_W_DEF-1){1'b0}}, 1'b1};
      end else if (avail > depth) begin
         result = depth;
      end else begin
         result = avail;
      end
      return result;
   endfunction

endpackage

// File: rtl/hazard_lookup.sv
// Youngest-match priority search of the in-flight writers for one ID operand.
// Reports whether a writer matched, its stage, and whether its result is not yet forwardable.
module hazard_lookup
   import hazard_pkg::*;
#(
   parameter int REG_BITS = REG_BITS_DEF,
   parameter int DEPTH    = DEPTH_DEF,
   parameter int SEL_W    = SEL_W_DEF
) (
   input  logic                enable,
   input  logic [REG_BITS-1:0] src,
   input  entry_t              entries [1:DEPTH],
   output logic                hit,
   output logic [SEL_W-1:0]    stage,
   output logic                hazard
);

   logic             match_s;
   logic [SEL_W-1:0] match_avail_s;

   // Scan oldest to youngest so the lowest matching stage is the one left standing.
   always_comb begin
      hit           = 1'b0;
      stage         = SEL_REGFILE;
      match_avail_s = SEL_REGFILE;
      match_s       = 1'b0;
      for (int s = DEPTH; s >= 1; s--) begin
         match_s       = enable && entries[s].valid && (entries[s].rd == src);
         hit           = match_s ? 1'b1 : hit;
         stage         = match_s ? SEL_W'(s) : stage;
         match_avail_s = match_s ? entries[s].avail : match_avail_s;
      end
      hazard = hit && (stage < match_avail_s);
   end

endmodule

// File: rtl/branch_hazard_scoreboard.sv
// ID-stage operand hazard unit: tracks in-flight register writers per stage and
// produces branch-operand forward selects, or a stall until a result is forwardable.
module branch_hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int REG_BITS = REG_BITS_DEF,
   parameter int DEPTH    = DEPTH_DEF,
   parameter int SEL_W    = $clog2(DEPTH + 1),
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                id_valid,
   input  logic                id_use_a,
   input  logic                id_use_b,
   input  logic [REG_BITS-1:0] id_src_a,
   input  logic [REG_BITS-1:0] id_src_b,
   input  logic                id_wr,
   input  logic [REG_BITS-1:0] id_rd,
   input  logic [SEL_W-1:0]    id_avail,
   input  logic                flush,
   output logic                stall,
   output logic [SEL_W-1:0]    fwd_a,
   output logic [SEL_W-1:0]    fwd_b,
   output logic [CNT_W-1:0]    stall_cycles
);

   localparam logic [SEL_W-1:0] DEPTH_SEL = SEL_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   entry_t           entries_r [1:DEPTH];
   state_t           state_r;
   logic [CNT_W-1:0] stall_cycles_r;

   logic             en_a_s;
   logic             en_b_s;
   logic             hit_a_s;
   logic             hit_b_s;
   logic             haz_a_s;
   logic             haz_b_s;
   logic [SEL_W-1:0] stage_a_s;
   logic [SEL_W-1:0] stage_b_s;
   logic             stall_s;
   logic             alloc_s;
   entry_t           new_entry_s;

   assign en_a_s = id_valid && id_use_a && (id_src_a != {REG_BITS{1'b0}});
   assign en_b_s = id_valid && id_use_b && (id_src_b != {REG_BITS{1'b0}});

   hazard_lookup #(
      .REG_BITS (REG_BITS),
      .DEPTH    (DEPTH),
      .SEL_W    (SEL_W)
   ) u_lookup_a (
      .enable  (en_a_s),
      .src     (id_src_a),
      .entries (entries_r),
      .hit     (hit_a_s),
      .stage   (stage_a_s),
      .hazard  (haz_a_s)
   );

   hazard_lookup #(
      .REG_BITS (REG_BITS),
      .DEPTH    (DEPTH),
      .SEL_W    (SEL_W)
   ) u_lookup_b (
      .enable  (en_b_s),
      .src     (id_src_b),
      .entries (entries_r),
      .hit     (hit_b_s),
      .stage   (stage_b_s),
      .hazard  (haz_b_s)
   );

   // Outputs stay quiet while reset clears the scoreboard; flush beats stall as ID is dead.
   always_comb begin
      stall_s = 1'b0;
      fwd_a   = SEL_REGFILE;
      fwd_b   = SEL_REGFILE;
      if (reset) begin
         stall_s = 1'b0;
         fwd_a   = SEL_REGFILE;
         fwd_b   = SEL_REGFILE;
      end else begin
         stall_s = (haz_a_s || haz_b_s) && !flush;
         fwd_a   = (hit_a_s && !haz_a_s) ? stage_a_s : SEL_REGFILE;
         fwd_b   = (hit_b_s && !haz_b_s) ? stage_b_s : SEL_REGFILE;
      end
   end

   assign alloc_s = id_valid && id_wr && (id_rd != {REG_BITS{1'b0}}) && !stall_s && !flush;

   // Stage-1 entry for the instruction leaving ID, or a bubble.
   always_comb begin
      new_entry_s = ENTRY_NONE;
      if (alloc_s) begin
         new_entry_s.valid = 1'b1;
         new_entry_s.rd    = id_rd;
         new_entry_s.avail = clamp_avail(id_avail, DEPTH_SEL);
      end else begin
         new_entry_s = ENTRY_NONE;
      end
   end

   // Scoreboard shift, RUN/STALL tracking and saturating stall statistics.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 1; s <= DEPTH; s++) begin
            entries_r[s] <= ENTRY_NONE;
         end
         state_r        <= RUN;
         stall_cycles_r <= {CNT_W{1'b0}};
      end else begin
         for (int s = DEPTH; s >= 2; s--) begin
            entries_r[s] <= entries_r[s-1];
         end
         entries_r[1] <= new_entry_s;
         case (state_r)
            RUN:     state_r <= stall_s ? STALL : RUN;
            STALL:   state_r <= stall_s ? STALL : RUN;
            default: state_r <= RUN;
         endcase
         if (stall_s && (stall_cycles_r != CNT_MAX)) begin
            stall_cycles_r <= stall_cycles_r + CNT_W'(1);
         end else begin
            stall_cycles_r <= stall_cycles_r;
         end
      end
   end

   assign stall        = stall_s;
   assign stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_branch_hazard_scoreboard.sv
// Directed bench: expected outputs are queued when each ID pattern is driven and
// compared on the falling edge; a narrow-counter copy checks saturation.
module tb_branch_hazard_scoreboard;

   logic       clk = 1'b0;
   logic       reset;
   logic       id_valid;
   logic       id_use_a;
   logic       id_use_b;
   logic [4:0] id_src_a;
   logic [4:0] id_src_b;
   logic       id_wr;
   logic [4:0] id_rd;
   logic [1:0] id_avail;
   logic       flush;

   logic        stall;
   logic [1:0]  fwd_a;
   logic [1:0]  fwd_b;
   logic [15:0] stall_cycles;
   logic        stall_n;
   logic [1:0]  fwd_a_n;
   logic [1:0]  fwd_b_n;
   logic [2:0]  stall_cycles_n;

   typedef struct {
      string      tag;
      logic       st;
      logic [1:0] fa;
      logic [1:0] fb;
   } exp_t;

   exp_t expq[$];
   int   checks  = 0;
   int   errors  = 0;
   int   exp_cnt = 0;

   always #5 clk = ~clk;

   branch_hazard_scoreboard dut (
      .clk          (clk),
      .reset        (reset),
      .id_valid     (id_valid),
      .id_use_a     (id_use_a),
      .id_use_b     (id_use_b),
      .id_src_a     (id_src_a),
      .id_src_b     (id_src_b),
      .id_wr        (id_wr),
      .id_rd        (id_rd),
      .id_avail     (id_avail),
      .flush        (flush),
      .stall        (stall),
      .fwd_a        (fwd_a),
      .fwd_b        (fwd_b),
      .stall_cycles (stall_cycles)
   );

   branch_hazard_scoreboard #(.CNT_W(3)) dut_narrow (
      .clk          (clk),
      .reset        (reset),
      .id_valid     (id_valid),
      .id_use_a     (id_use_a),
      .id_use_b     (id_use_b),
      .id_src_a     (id_src_a),
      .id_src_b     (id_src_b),
      .id_wr        (id_wr),
      .id_rd        (id_rd),
      .id_avail     (id_avail),
      .flush        (flush),
      .stall        (stall_n),
      .fwd_a        (fwd_a_n),
      .fwd_b        (fwd_b_n),
      .stall_cycles (stall_cycles_n)
   );

   task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s.%s observed %0d expected %0d", tag, what, obs, expv);
      end
   endtask

   task automatic drive(input int v, input int ua, input int ub, input int sa, input int sb,
                        input int w, input int rd, input int av, input int fl);
      id_valid = v[0];
      id_use_a = ua[0];
      id_use_b = ub[0];
      id_src_a = sa[4:0];
      id_src_b = sb[4:0];
      id_wr    = w[0];
      id_rd    = rd[4:0];
      id_avail = av[1:0];
      flush    = fl[0];
   endtask

   task automatic cyc(input string tag, input int st, input int fa, input int fb);
      exp_t e;
      int   sat;
      e.tag = tag;
      e.st  = st[0];
      e.fa  = fa[1:0];
      e.fb  = fb[1:0];
      expq.push_back(e);
      @(negedge clk);
      e   = expq.pop_front();
      sat = (exp_cnt > 7) ? 7 : exp_cnt;
      chk(e.tag, "stall", 32'(stall), 32'(e.st));
      chk(e.tag, "fwd_a", 32'(fwd_a), 32'(e.fa));
      chk(e.tag, "fwd_b", 32'(fwd_b), 32'(e.fb));
      chk(e.tag, "stall_cycles", 32'(stall_cycles), 32'(exp_cnt));
      chk(e.tag, "narrow_stall", 32'(stall_n), 32'(e.st));
      chk(e.tag, "narrow_cycles", 32'(stall_cycles_n), 32'(sat));
      if (e.st) exp_cnt++;
      @(posedge clk);
      if (reset) exp_cnt = 0;
      #1;
   endtask

   initial begin
      reset = 1'b1;
      drive(1, 1, 0, 8, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      cyc("reset", 0, 0, 0);
      reset = 1'b0;

      // ALU writer then dependent branch
      drive(1, 0, 0, 0, 0, 1, 8, 2, 0);  cyc("alu_wr", 0, 0, 0);
      drive(1, 1, 0, 8, 0, 0, 0, 0, 0);  cyc("alu_stall", 1, 0, 0);
      cyc("alu_fwd", 0, 2, 0);
      cyc("alu_wb", 0, 3, 0);
      cyc("alu_retired", 0, 0, 0);

      // Load-use on both operands; ID's own write must not leak during stall
      drive(1, 0, 0, 0, 0, 1, 9, 3, 0);  cyc("ld_wr", 0, 0, 0);
      drive(1, 1, 1, 9, 9, 1, 11, 2, 0); cyc("ld_stall1", 1, 0, 0);
      cyc("ld_stall2", 1, 0, 0);
      drive(1, 1, 1, 9, 9, 0, 0, 0, 0);  cyc("ld_fwd", 0, 3, 3);
      drive(1, 1, 0, 11, 0, 0, 0, 0, 0); cyc("ld_no_alloc", 0, 0, 0);

      // Two writers to $10: youngest (avail 0 clamps to 1) wins
      drive(1, 0, 0, 0, 0, 1, 10, 3, 0);  cyc("w10_old", 0, 0, 0);
      drive(1, 0, 0, 0, 0, 1, 10, 0, 0);  cyc("w10_young", 0, 0, 0);
      drive(1, 1, 1, 10, 10, 0, 0, 0, 0); cyc("w10_youngest", 0, 1, 1);
      drive(1, 0, 1, 10, 10, 0, 0, 0, 0); cyc("w10_s2", 0, 0, 2);

      // Register $0 never allocates nor forwards
      drive(1, 1, 0, 0, 0, 1, 0, 2, 0);  cyc("w0", 0, 0, 0);
      drive(1, 1, 1, 0, 0, 0, 0, 0, 0);  cyc("use0", 0, 0, 0);

      // Flush with pending hazard
      drive(1, 0, 0, 0, 0, 1, 13, 3, 0);  cyc("fl_wr", 0, 0, 0);
      drive(1, 1, 0, 13, 0, 1, 14, 2, 1); cyc("fl_flush", 0, 0, 0);
      drive(1, 1, 0, 14, 0, 0, 0, 0, 0);  cyc("fl_no_alloc", 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);   cyc("fl_idle", 0, 0, 0);

      // Reset in the middle of a load-use stall
      drive(1, 0, 0, 0, 0, 1, 15, 3, 0);  cyc("rs_ld", 0, 0, 0);
      drive(1, 1, 0, 15, 0, 0, 0, 0, 0);  cyc("rs_stall", 1, 0, 0);
      reset = 1'b1;                       cyc("rs_reset", 0, 0, 0);
      reset = 1'b0;                       cyc("rs_after", 0, 0, 0);

      // Repeated load-use pairs drive the narrow counter into saturation
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 0, 0, 0, 1, 16, 3, 0); cyc("sat_ld", 0, 0, 0);
         drive(1, 1, 0, 16, 0, 0, 0, 0, 0); cyc("sat_stall1", 1, 0, 0);
         cyc("sat_stall2", 1, 0, 0);
         cyc("sat_fwd", 0, 3, 0);
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);   cyc("sat_final", 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_hazard_scoreboard.md
# branch_hazard_scoreboard

Parametrised ID-stage operand hazard unit for the MIPS pipeline, generalising branch forwarding from a fixed MEM/WB pair to a DEPTH-stage scoreboard of in-flight register writers. It records every writer that leaves ID together with the stage at which its result becomes forwardable. Each cycle it produces per-operand forward selects for the instruction in ID, or a stall when a needed result is not yet available. It sits beside the ID stage and drives the ID bypass muxes and the IF/ID hold and ID/EX bubble controls.

## Interface
- REG_BITS, 5: register index width.
- DEPTH, 3: number of tracked stages after ID (1 = EX, DEPTH = WB).
- SEL_W, $clog2(DEPTH+1): width of select and availability fields.
- CNT_W, 16: width of the stall statistics counter.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_use_a / id_use_b  in  1  ID consumes operand A/B in ID (branch compare).
- id_src_a / id_src_b  in  REG_BITS  source register indices.
- id_wr  in  1  ID instruction writes a register.
- id_rd  in  REG_BITS  destination index.
- id_avail  in  SEL_W  first stage whose output carries the result (ALU = 2, load = 3).
- flush  in  1  kill the ID instruction this cycle.
- stall  out  1  hold IF/ID, insert bubble into stage 1.
- fwd_a / fwd_b  out  SEL_W  0 = register file, s = forward from stage s.
- stall_cycles  out  CNT_W  saturating count of stalled cycles.

## Operation
- Scoreboard: DEPTH entries {valid, rd, avail}; entry s is the writer currently in stage s.
- id_avail clamp: 0 is treated as 1; values above DEPTH are treated as DEPTH.
- Lookup per operand X, used only when id_valid && id_use_X && id_src_X != 0:
  - Take the lowest s with entry[s].valid && entry[s].rd == id_src_X; the youngest writer wins.
  - If s >= entry[s].avail, then fwd_X = s, with no hazard.
  - If s < entry[s].avail, there is a hazard, and fwd_X = 0 (don't-care).
  - If nothing matches, fwd_X = 0.
- Unused operands and register 0 always give fwd = 0 and never cause a hazard.
- stall = (hazard_a || hazard_b) && !flush. flush overrides stall because the held instruction is dead.
- Shift every cycle: entry[s+1] <= entry[s] for s = 1..DEPTH-1. entry[DEPTH] is retired, after which the register file holds the value (written at the end of stage DEPTH).
- Stage-1 load: entry[1] <= {1, id_rd, clamp(id_avail)} when id_valid && id_wr && id_rd != 0 && !stall && !flush; otherwise entry[1] becomes invalid (bubble).
- FSM: RUN / STALL.
  - RUN→STALL when stall = 1.
  - STALL→RUN when stall = 0.
  - The state is registered; stall_cycles increments on every cycle where stall = 1, saturating at all-ones.

## Timing
- stall and fwd_* are combinational from the ID inputs and registered entries, valid in the same cycle.
- The scoreboard updates at the clock edge.
- Stall length for a single hazard is exactly entry.avail - s cycles. Example: a load (avail 3) in EX (s = 1) followed by a dependent branch stalls 2 cycles, then gives fwd = 3.
- Simultaneous hazards on A and B take the maximum of the two stall lengths.
- A DEPTH-to-DEPTH+1 transition needs no forwarding; fwd returns to 0.
- Reset:
  - All entries become invalid, the state goes to RUN, and stall_cycles = 0.
  - Outputs in the reset cycle are stall = 0 and fwd_a = fwd_b = 0.
  - Reset mid-stall ends the stall on the next cycle.
- flush with a pending hazard: stall = 0 in that cycle, and no entry is allocated.

## Structure
- A shared package `hazard_pkg` holds:
  - the entry struct {valid, rd, avail};
  - the state enum RUN/STALL;
  - the constant SEL_REGFILE = 0.
- One sub-module is natural: `hazard_lookup`, instantiated once per operand. It is a combinational youngest-match priority search returning {hit, stage, hazard}.
- The shift register, the FSM and the counter live in the top module.

## Test plan
- ALU writer $8 (avail 2), then a branch using $8 in the next cycle: stall = 1 for 1 cycle, then fwd_a = 2, stall_cycles = 1.
- Load $9 (avail 3), then a branch using rs = rt = $9: stall for 2 cycles; afterwards fwd_a = fwd_b = 3, and no stage-1 entry is allocated during the stall.
- Two writers to $10 in consecutive cycles, then a branch using $10: the youngest, at s = 1 with avail 1, is selected, giving fwd = 1 with no stall.
- Writer to $0 and a branch using $0: fwd = 0, stall = 0, and no entry is allocated.
- Hazard pending with flush = 1: stall = 0, and the next cycle shows entry[1] invalid.
- Reset asserted during a 2-cycle load-use stall:
  - next cycle has stall = 0 and stall_cycles = 0;
  - counter saturation holds at 16'hFFFF with CNT_W = 16 forced near the limit.
